// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multicycle RV32I core: PC, previous PC and IR,
// plus the instruction-memory request/response sequencing.
package fetch_pkg;
  typedef logic [6:0] opcode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ir_write,
  input  logic         pc_update,
  input  logic         branch,
  input  logic         pc_src,
  input  logic [31:0]  pc_target,
  output logic         imem_req_valid,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic [31:0]  instr,
  output opcode_t      opcode,
  output logic [31:0]  pc,
  output logic [31:0]  old_pc,
  output logic         fetch_stall,
  output logic         fetch_done,
  output logic         misaligned,
  output fetch_state_t state_dbg
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, old_pc_q, instr_q;
  logic         misaligned_q;
  logic         pc_take;
  logic         target_bad;

  // Handshake: a request transfers on a clock edge where imem_req_valid and
  // imem_req_ready are both high; valid and address stay stable until then.
  // A response transfers on any edge in S_WAIT with imem_rsp_valid high; the
  // memory has no back-pressure on responses and responses outside S_WAIT are dropped.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign fetch_done     = (state_q == S_WAIT) && imem_rsp_valid;
  assign fetch_stall    = ir_write && !fetch_done;

  assign instr      = instr_q;
  assign opcode     = instr_q[6:0];
  assign pc         = pc_q;
  assign old_pc     = old_pc_q;
  assign misaligned = misaligned_q;
  assign state_dbg  = state_q;

  // Not-taken branches leave pc alone: PC+4 was already applied at fetch.
  assign pc_take    = (state_q == S_IDLE) && pc_update && (!branch || pc_src);
  assign target_bad = (pc_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ir_write) state_d = S_REQ;
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= RESET_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        instr_q  <= imem_rsp_data;
        old_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end else if (pc_take) begin
        if (target_bad) misaligned_q <= 1'b1;
        else            pc_q         <= pc_target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a driver plays controller and
// instruction memory, a monitor checks every captured instruction and PC.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ir_write = 1'b0, pc_update = 1'b0, branch = 1'b0, pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr, pc, old_pc;
  logic [6:0]  opcode;
  logic        fetch_stall, fetch_done, misaligned;
  logic [1:0]  state_dbg;

  fetch_unit #(.RESET_PC(RESET_PC), .RESET_INSTR(RESET_INSTR)) dut (
    .clk(clk), .reset(reset), .ir_write(ir_write), .pc_update(pc_update),
    .branch(branch), .pc_src(pc_src), .pc_target(pc_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr(instr), .opcode(opcode), .pc(pc),
    .old_pc(old_pc), .fetch_stall(fetch_stall), .fetch_done(fetch_done),
    .misaligned(misaligned), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {instr, old_pc, pc, cycle in which fetch_done must be high}
  logic [127:0] exp_q[$];
  logic [31:0]  m_pc = RESET_PC;
  logic         m_mis = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of an accepted pc_update in IDLE
  function automatic void model_update(input bit br, input bit src, input logic [31:0] t);
    if (!br || src) begin
      if (t % 4 != 0) m_mis = 1'b1;
      else            m_pc  = t;
    end
  endfunction

  // Monitor: checks the IR/PC one cycle after every fetch_done pulse
  bit pend = 0;
  always @(negedge clk) begin
    logic [127:0] e;
    #2;
    if (pend) begin
      pend = 0;
      e = exp_q.pop_front();
      chk("instr", instr, e[127:96]);
      chk("opcode", {25'd0, opcode}, {25'd0, e[102:96]});
      chk("old_pc", old_pc, e[95:64]);
      chk("pc_after_fetch", pc, e[63:32]);
    end
    if (fetch_done) begin
      if (exp_q.size() == 0) chk("unexpected_fetch_done", 32'd1, 32'd0);
      else begin
        chk("fetch_done_cycle", cyc, exp_q[0][31:0]);
        pend = 1;
      end
    end
  end

  // One full fetch: rw cycles of ready low, sw cycles before the response.
  // upd: pc_update jump issued together with ir_write; bad: pc_update during WAIT.
  task automatic do_fetch(input int rw, input int sw, input logic [31:0] data,
                          input bit upd, input logic [31:0] tgt, input bit bad);
    logic [31:0] a;
    int n;
    if (upd) begin
      pc_update = 1; branch = 0; pc_src = 0; pc_target = tgt;
      model_update(0, 0, tgt);
    end
    a = m_pc;
    exp_q.push_back({data, a, a + 32'd4, cyc + 32'd2 + 32'(rw) + 32'(sw)});
    m_pc = a + 32'd4;
    ir_write = 1;
    @(negedge clk);
    pc_update = 0;
    n = 0;
    while (!imem_req_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, a);
    repeat (rw) begin
      @(negedge clk);
      chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("req_hold_addr", imem_req_addr, a);
      chk("stall_in_req", {31'd0, fetch_stall}, 32'd1);
    end
    imem_req_ready = 1;
    @(negedge clk);
    imem_req_ready = 0;
    if (bad) begin
      pc_update = 1; branch = 0; pc_target = $urandom() & 32'hFFFF_FFFC;
    end
    repeat (sw) begin
      imem_rsp_valid = 0;
      #1;
      chk("stall_in_wait", {31'd0, fetch_stall}, 32'd1);
      chk("no_early_done", {31'd0, fetch_done}, 32'd0);
      @(negedge clk);
      pc_update = 0;
    end
    imem_rsp_valid = 1;
    imem_rsp_data = data;
    #1;
    chk("done_on_rsp", {31'd0, fetch_done}, 32'd1);
    chk("stall_released", {31'd0, fetch_stall}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 0;
    imem_rsp_data = $urandom();
    ir_write = 0;
  endtask

  task automatic do_update(input bit br, input bit src, input logic [31:0] t);
    pc_update = 1; branch = br; pc_src = src; pc_target = t;
    model_update(br, src, t);
    @(negedge clk);
    pc_update = 0; branch = 0; pc_src = 0;
    chk("pc_after_update", pc, m_pc);
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  task automatic stray_rsp();
    imem_rsp_valid = 1;
    imem_rsp_data = $urandom();
    #1;
    chk("stray_rsp_ignored", {31'd0, fetch_done}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 0;
    chk("stray_rsp_pc", pc, m_pc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_old_pc"}, old_pc, RESET_PC);
    chk({tag, "_instr"}, instr, RESET_INSTR);
    chk({tag, "_opcode"}, {25'd0, opcode}, 32'h13);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    chk({tag, "_fetch_done"}, {31'd0, fetch_done}, 32'd0);
    chk({tag, "_state_idle"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kind, rw, sw;
    bit b1, b2;
    logic [31:0] t;
    repeat (2) @(negedge clk);
    reset = 0;
    check_reset_state("reset");

    do_fetch(0, 0, 32'h0050_0093, 0, 0, 0);   // minimum latency
    do_fetch(3, 2, $urandom(), 0, 0, 0);      // back-pressure, latency 7
    do_update(0, 0, 32'h100);
    do_update(0, 0, 32'h200);
    do_update(1, 0, 32'h0000_0800);
    do_update(1, 1, 32'h40);
    do_update(0, 0, 32'h102);                  // misaligned: pc kept, flag set
    do_update(0, 0, 32'h300);                  // flag stays sticky
    do_fetch(0, 2, $urandom(), 0, 0, 1);       // update during WAIT ignored
    do_update(0, 0, 32'hFFFF_FFFC);
    do_fetch(1, 1, $urandom(), 0, 0, 0);       // wraps to 0
    do_fetch(0, 1, $urandom(), 1, 32'h500, 0); // update and fetch together
    stray_rsp();

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      sw = $urandom_range(0, 3);
      b1 = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      t = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      case (kind)
        0, 1: do_fetch(rw, sw, $urandom(), b1, $urandom() & 32'hFFFF_FFFC, (sw > 0) && b2);
        2:    do_update(b1, b2, t);
        default: stray_rsp();
      endcase
    end

    // Reset while waiting for a response; the late response must be dropped
    ir_write = 1;
    @(negedge clk);
    imem_req_ready = 1;
    @(negedge clk);
    imem_req_ready = 0;
    reset = 1;
    ir_write = 0;
    @(negedge clk);
    reset = 0;
    m_pc = RESET_PC;
    m_mis = 0;
    imem_rsp_valid = 1;
    imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("late_rsp_no_done", {31'd0, fetch_done}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 0;
    check_reset_state("mid_fetch_reset");

    do_fetch(0, 0, $urandom(), 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the multicycle RV32I core. It holds the program counter, the previous PC and the instruction register, and runs the instruction-memory request/response handshake. It sits directly upstream of the control FSM: it supplies `opcode` and executes the FSM's `IRWrite`, `PCUpdate`, `pc_src` and `Branch` strobes. While a fetch is in flight it raises `fetch_stall`, and the controller holds its FETCH state until `fetch_done`.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset. Must be word-aligned.
- `RESET_INSTR`, default `32'h0000_0013`: IR value after reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `ir_write`  in  1  fetch request from the controller; held high through the whole FETCH state
- `pc_update`  in  1  PC update strobe from the controller
- `branch`  in  1  qualifies `pc_update` as a conditional branch
- `pc_src`  in  1  branch taken; only meaningful when `branch`=1
- `pc_target`  in  32  jump/branch target computed by the ALU
- `imem_req_valid`  out  1  request valid
- `imem_req_addr`  out  32  request byte address
- `imem_req_ready`  in  1  memory accepts the request
- `imem_rsp_valid`  in  1  response data valid
- `imem_rsp_data`  in  32  instruction word
- `instr`  out  32  instruction register
- `opcode`  out  7 (`opcode_t`)  equal to `instr[6:0]`
- `pc`  out  32  current PC
- `old_pc`  out  32  PC of the instruction held in `instr`
- `fetch_stall`  out  1  the controller must stay in FETCH
- `fetch_done`  out  1  one-cycle pulse; the IR is captured at this clock edge
- `misaligned`  out  1  sticky flag: a target with `pc_target[1:0]`≠0 was rejected

## Operation
The fetch state machine has three states: IDLE, REQ and WAIT.
- **IDLE:** `imem_req_valid`=0. If `ir_write`=1, go to REQ.
- **REQ:**
  - `imem_req_valid`=1 and `imem_req_addr`=`pc`, both from registers.
  - Hold valid and address stable until `imem_req_ready`=1, then go to WAIT.
  - Valid never drops before acceptance, even if `ir_write` deasserts.
- **WAIT:**
  - Wait for `imem_rsp_valid`=1.
  - At that edge: `instr`←`imem_rsp_data`, `old_pc`←`pc`, `pc`←`pc+4`, then go to IDLE.
  - Once accepted, a request always completes and its response is always captured.
- **Outputs:**
  - `fetch_done` = (state==WAIT && `imem_rsp_valid`), combinational.
  - `fetch_stall` = `ir_write` && !`fetch_done`.
- **PC update (only in IDLE with `pc_update`=1):**
  - `branch`=0: jump, `pc`←`pc_target`.
  - `branch`=1, `pc_src`=1: taken branch, `pc`←`pc_target`.
  - `branch`=1, `pc_src`=0: `pc` is unchanged (PC+4 was already applied at fetch).
  - If the selected target has `pc_target[1:0]`≠0: `pc` is unchanged and `misaligned`←1. The flag stays set until reset.
  - `pc_update` outside IDLE is a protocol violation: it is ignored and `pc` is unchanged.
  - `pc_update` and `ir_write` together in IDLE: the update applies first. REQ then issues the new `pc`.
- **Arithmetic:** `pc+4` is 32-bit modulo. `32'hFFFF_FFFC` wraps to `32'h0000_0000`, with no flag.
- **Response before request:** `imem_rsp_valid` outside WAIT is ignored.

## Timing
- **Reset:** state IDLE, `pc`=`old_pc`=`RESET_PC`, `instr`=`RESET_INSTR`, `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `misaligned`=0, `fetch_done`=0.
- **Reset mid-fetch:** abandons the transaction. The unit is in IDLE next cycle, and a late response is dropped.
- **Minimum fetch latency (ready=1, response one cycle after acceptance):**
  - cycle 0: `ir_write` rises.
  - cycle 1: REQ, accepted.
  - cycle 2: WAIT, response, `fetch_done`.
  - `instr` and `pc` are new at cycle 3. Fetch latency is 2 + ready-wait + response-wait cycles.
- **Response timing:** the response must arrive no earlier than the cycle after acceptance.
- **Timing of PC writes:** `pc` and `old_pc` change only at the `fetch_done` edge or at an accepted `pc_update` edge.

## Test plan
- **Reset, then one fetch** with ready=1 and the response 1 cycle later carrying `32'h00500093`: `fetch_done` is high in cycle 2 only. Then `instr`=`32'h00500093`, `opcode`=`7'h13`, `old_pc`=0, `pc`=4.
- **Back-pressure:** ready low for 3 cycles and the response delayed 2 cycles. `imem_req_valid`/`imem_req_addr` stay stable the whole time, `fetch_stall` stays high until the response, and the total latency is 7 cycles.
- **Jump and branch:**
  - With `pc`=`32'h100`: `pc_update`, `branch`=0, `pc_target`=`32'h200` gives `pc`=`32'h200`.
  - Then `branch`=1, `pc_src`=0 leaves `pc`=`32'h200`.
  - Then `branch`=1, `pc_src`=1, `pc_target`=`32'h40` gives `pc`=`32'h40`.
- **Misaligned target:** `pc_update` with `pc_target`=`32'h102` leaves `pc` unchanged and sets `misaligned`=1. The flag stays set after a later good jump and clears only on reset.
- **Illegal update:** `pc_update` during WAIT leaves `pc` unchanged. Separately, `pc`=`32'hFFFF_FFFC` fetched gives `pc`=0 after `fetch_done`.
- **Reset during WAIT, with the response arriving the next cycle:** `instr`=`RESET_INSTR`, `pc`=`RESET_PC`, and `fetch_done` never pulses.
